imm_gen_pipe: RTL and testbench

Pipelined, parameterised RV32I immediate generator. It sits between instruction fetch/decode and the ALU operand mux. It accepts one instruction per cycle over a valid/ready handshake. For every instruction it emits the sign-extended immediate together with a format tag. Coverage is all RV32I immediate formats (I, S, B, U, J), with configurable pipeline depth and output width, and full backpressure support.

---
 rtl/imm_gen_pipe.sv | 175 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I immediate generator with an elastic valid/ready pipeline.
// Optional illegal-opcode counter enabled by defining IMMGEN_ILLEGAL_CNT_EN.
module imm_gen_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm_out,
   output logic [2:0]      fmt_out,
   output logic [15:0]     illegal_cnt
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;
   localparam logic [2:0] FMT_X = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
   } payload_t;

   logic [6:0]  opcode;
   logic        is_i;
   logic        is_s;
   logic        is_b;
   logic        is_u;
   logic        is_j;
   logic        is_r;
   logic [31:0] imm32;
   logic [2:0]  dec_fmt;
   payload_t    dec;

   logic [STAGES:0]   rdy;
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_d;
   payload_t          pl_q [STAGES];
   payload_t          pl_d [STAGES];

   // Opcode classification; the classes are mutually exclusive.
   always_comb begin
      opcode = instr[6:0];
      is_i   = (opcode == 7'b0010011) || (opcode == 7'b0000011) ||
               (opcode == 7'b1100111) || (opcode == 7'b1110011);
      is_s   = (opcode == 7'b0100011);
      is_b   = (opcode == 7'b1100011);
      is_u   = (opcode == 7'b0110111) || (opcode == 7'b0010111);
      is_j   = (opcode == 7'b1101111);
      is_r   = (opcode == 7'b0110011);
   end

   // Immediate assembly per format, 32-bit sign-extended.
   always_comb begin
      imm32   = '0;
      dec_fmt = FMT_X;
      unique case (1'b1)
         is_i: begin
            imm32   = {{20{instr[31]}}, instr[31:20]};
            dec_fmt = FMT_I;
         end
         is_s: begin
            imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            dec_fmt = FMT_S;
         end
         is_b: begin
            imm32   = {{19{instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            dec_fmt = FMT_B;
         end
         is_u: begin
            imm32   = {instr[31:12], 12'b0};
            dec_fmt = FMT_U;
         end
         is_j: begin
            imm32   = {{11{instr[31]}}, instr[31], instr[19:12],
                       instr[20], instr[30:21], 1'b0};
            dec_fmt = FMT_J;
         end
         is_r: begin
            imm32   = '0;
            dec_fmt = FMT_R;
         end
         default: begin
            imm32   = '0;
            dec_fmt = FMT_X;
         end
      endcase
   end

   // Widen to XLEN by replicating the 32-bit sign bit.
   always_comb begin
      dec.imm        = {XLEN{imm32[31]}};
      dec.imm[31:0]  = imm32;
      dec.fmt        = dec_fmt;
   end

   // Ready chain: a stage can take data if empty or if its successor moves.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = !v_q[k] || rdy[k+1];
      end
   end

   // Next state: ready stages shift in from upstream, stalled stages hold.
   always_comb begin
      v_d  = v_q;
      pl_d = pl_q;
      if (rdy[0]) begin
         v_d[0]  = in_valid;
         pl_d[0] = dec;
      end
      for (int k = 1; k < STAGES; k++) begin
         if (rdy[k]) begin
            v_d[k]  = v_q[k-1];
            pl_d[k] = pl_q[k-1];
         end
      end
   end

   // Pipeline registers; reset flushes all in-flight entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            pl_q[k] <= '0;
         end
      end else begin
         v_q  <= v_d;
         pl_q <= pl_d;
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v_q[STAGES-1];
   assign imm_out   = pl_q[STAGES-1].imm;
   assign fmt_out   = pl_q[STAGES-1].fmt;

`ifdef IMMGEN_ILLEGAL_CNT_EN
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Saturating count of illegal opcodes taken at the input handshake.
   always_comb begin
      cnt_d = cnt_q;
      if (in_valid && rdy[0] && (dec_fmt == FMT_X) && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Counter register, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign illegal_cnt = cnt_q;
`else
   assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe (XLEN=64, STAGES=3).
// Counter checks follow IMMGEN_ILLEGAL_CNT_EN when defined.
module tb_imm_gen_pipe;

   localparam int XLEN   = 64;
   localparam int STAGES = 3;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] imm_out;
   logic [2:0]      fmt_out;
   logic [15:0]     illegal_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int mcnt     = 0;

   typedef struct {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      int              stamp;
   } item_t;

   item_t q[$];

   imm_gen_pipe #(
      .XLEN   (XLEN),
      .STAGES (STAGES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instr       (instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .imm_out     (imm_out),
      .fmt_out     (fmt_out),
      .illegal_cnt (illegal_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference decode: immediate value as a weighted sum of instruction fields.
   function automatic void ref_dec(input logic [31:0] w,
                                   output logic [63:0] imm,
                                   output logic [2:0] fmt);
      longint v;
      longint sgn;
      v   = 0;
      sgn = w[31] ? 1 : 0;
      fmt = 3'd7;
      case (w[6:0])
         7'h13, 7'h03, 7'h67, 7'h73: begin
            fmt = 3'd1;
            v   = longint'(w[31:20]) - sgn * 4096;
         end
         7'h23: begin
            fmt = 3'd2;
            v   = longint'(w[31:25]) * 32 + longint'(w[11:7]) - sgn * 4096;
         end
         7'h63: begin
            fmt = 3'd3;
            v   = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 +
                  longint'(w[11:8]) * 2 - sgn * 4096;
         end
         7'h37, 7'h17: begin
            fmt = 3'd4;
            v   = longint'(w[31:12]) * 4096 - sgn * (64'sd1 <<< 32);
         end
         7'h6F: begin
            fmt = 3'd5;
            v   = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 +
                  longint'(w[30:21]) * 2 - sgn * (64'sd1 <<< 20);
         end
         7'h33: begin
            fmt = 3'd0;
            v   = 0;
         end
         default: begin
            fmt = 3'd7;
            v   = 0;
         end
      endcase
      imm = v;
   endfunction

   // Per-cycle compare against the scoreboard, then model the coming edge.
   always @(negedge clk) begin
      logic [63:0] e_imm;
      logic [2:0]  e_fmt;
      item_t       it;
      logic        e_ov;
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_imm_out", imm_out, 0);
         chk("rst_fmt_out", fmt_out, 0);
         chk("rst_illegal_cnt", illegal_cnt, 0);
         q.delete();
         mcnt = 0;
      end else begin
         chk("in_ready", in_ready,
             (out_ready || (q.size() < STAGES)) ? 1 : 0);
         e_ov = (q.size() > 0) && ((cyc - q[0].stamp) >= STAGES - 1);
         chk("out_valid", out_valid, e_ov);
         if (out_valid && (q.size() > 0)) begin
            chk("imm_out", imm_out, q[0].imm);
            chk("fmt_out", fmt_out, q[0].fmt);
         end
`ifdef IMMGEN_ILLEGAL_CNT_EN
         chk("illegal_cnt", illegal_cnt, mcnt);
`else
         chk("illegal_cnt_off", illegal_cnt, 0);
`endif
         if (out_valid && out_ready && (q.size() > 0)) begin
            void'(q.pop_front());
         end
         if (in_valid && in_ready) begin
            ref_dec(instr, e_imm, e_fmt);
            it.imm   = e_imm[XLEN-1:0];
            it.fmt   = e_fmt;
            it.stamp = cyc + 1;
            q.push_back(it);
            if ((e_fmt == 3'd7) && (mcnt != 16'hFFFF)) begin
               mcnt++;
            end
         end
      end
      cyc++;
   end

   logic [31:0] stream [4];
   logic [31:0] bp     [4];
   logic [6:0]  ops    [10];

   initial begin
      logic [63:0] m_imm;
      logic [2:0]  m_fmt;
      logic [31:0] r;
      int          idx;
      int          acc;
      logic        took;

      stream = '{32'h0020A423, 32'hFE000EE3, 32'h123450B7, 32'hFF9FF06F};
      bp     = '{32'h00500113, 32'h00000033, 32'h800000B7, 32'h0000007F};
      ops    = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      instr     = '0;

      ref_dec(32'hFFF00093, m_imm, m_fmt);
      chk("model_addi_imm", m_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("model_addi_fmt", m_fmt, 1);
      ref_dec(32'h0020A423, m_imm, m_fmt);
      chk("model_sw_imm", m_imm, 64'h8);
      chk("model_sw_fmt", m_fmt, 2);
      ref_dec(32'hFE000EE3, m_imm, m_fmt);
      chk("model_beq_imm", m_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("model_beq_fmt", m_fmt, 3);
      ref_dec(32'h123450B7, m_imm, m_fmt);
      chk("model_lui_imm", m_imm, 64'h1234_5000);
      chk("model_lui_fmt", m_fmt, 4);
      ref_dec(32'hFF9FF06F, m_imm, m_fmt);
      chk("model_jal_imm", m_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("model_jal_fmt", m_fmt, 5);
      ref_dec(32'h0000007F, m_imm, m_fmt);
      chk("model_ill_fmt", m_fmt, 7);

      tick();
      tick();
      rst_n = 1'b1;

      // Single ADDI, latency STAGES from the accepting edge.
      repeat (STAGES + 1) tick();
      instr    = 32'hFFF00093;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (STAGES - 1) tick();
      @(negedge clk);
      #1;
      chk("lat_out_valid", out_valid, 1);
      chk("lat_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("lat_fmt", fmt_out, 1);

      // Back-to-back stream.
      tick();
      for (int i = 0; i < 4; i++) begin
         instr    = stream[i];
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      repeat (STAGES + 2) tick();

      // Backpressure: only STAGES entries fit while out_ready is low.
      out_ready = 1'b0;
      idx       = 0;
      acc       = 0;
      instr     = bp[0];
      in_valid  = 1'b1;
      repeat (6) begin
         @(negedge clk);
         #1;
         took = in_ready && in_valid;
         tick();
         if (took) begin
            acc++;
            idx++;
            if (idx < 4) instr = bp[idx];
            else in_valid = 1'b0;
         end
      end
      chk("bp_accepts", acc, STAGES);
      chk("bp_hold_valid", out_valid, 1);
      out_ready = 1'b1;
      for (int n = 0; n < 20 && idx < 4; n++) begin
         @(negedge clk);
         #1;
         took = in_ready && in_valid;
         tick();
         if (took) begin
            idx++;
            if (idx < 4) instr = bp[idx];
            else in_valid = 1'b0;
         end
      end
      chk("bp_all_accepted", idx, 4);
      in_valid = 1'b0;
      repeat (STAGES + 2) tick();

      // Reset with two entries in flight.
      out_ready = 1'b0;
      instr     = 32'h00A00093;
      in_valid  = 1'b1;
      tick();
      instr     = 32'h0020A423;
      tick();
      in_valid  = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      tick();
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (STAGES + 3) tick();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         r        = $urandom();
         in_valid = ($urandom_range(0, 9) < 7);
         if (i < 1000) out_ready = ($urandom_range(0, 9) < 9);
         else out_ready = ($urandom_range(0, 9) < 5);
         if ($urandom_range(0, 9) < 8) begin
            instr = {r[31:7], ops[$urandom_range(0, 9)]};
         end else begin
            instr = r;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (STAGES + 2) tick();

`ifdef IMMGEN_ILLEGAL_CNT_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      instr = 32'h0000007F;
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      repeat (STAGES + 1) tick();
      chk("cnt_three", illegal_cnt, 3);
      in_valid = 1'b1;
      repeat (65535) tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("cnt_saturate", illegal_cnt, 16'hFFFF);
`else
      chk("cnt_tied_zero", illegal_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
